// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the seg7_scan_driver display block.
// Glyphs are abcdefg, active-low (0 = segment lit).
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;
  localparam logic [6:0] SEG7_E     = 7'b0110000;
  localparam logic [6:0] SEG7_R     = 7'b1111010;
  localparam logic [6:0] SEG7_G     = 7'b0000100;
  localparam logic [6:0] SEG7_O     = 7'b1100010;
  localparam logic [6:0] SEG7_D     = 7'b1000010;

  function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = SEG7_BLANK;
    endcase
    return g;
  endfunction

  function automatic int seg7_div(input int clk_hz, input int digit_hz);
    return clk_hz / digit_hz;
  endfunction

endpackage

// File: rtl/seg7_glyph_sel.sv
// Combinational glyph choice for one digit: Err / good status text take
// priority over the hex nibble; lzb blanks a leading-zero hex digit.
module seg7_glyph_sel
  import seg7_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int IDXW    = 2
) (
  input  logic [3:0]      nibble,
  input  logic [IDXW-1:0] idx,
  input  logic            err_d,
  input  logic            good_d,
  input  logic            lzb,
  output logic [6:0]      glyph
);

  logic [IDXW-1:0] off_s;

  // Status text is laid out from the leftmost digit, so select on distance from it.
  always_comb begin
    off_s = IDXW'(NDIGITS - 1) - idx;
    glyph = SEG7_BLANK;
    if (err_d) begin
      case (off_s)
        IDXW'(0): glyph = SEG7_E;
        IDXW'(1): glyph = SEG7_R;
        IDXW'(2): glyph = SEG7_R;
        default:  glyph = SEG7_BLANK;
      endcase
    end else if (good_d) begin
      case (off_s)
        IDXW'(0): glyph = SEG7_G;
        IDXW'(1): glyph = SEG7_O;
        IDXW'(2): glyph = SEG7_O;
        IDXW'(3): glyph = SEG7_D;
        default:  glyph = SEG7_BLANK;
      endcase
    end else if (lzb) begin
      glyph = SEG7_BLANK;
    end else begin
      glyph = seg7_hex(nibble);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned updates.
// Define SEG7_LZB_EN to enable leading-zero blanking in hex mode.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 4000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   err,
  input  logic                   good,
  output logic                   ready,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an
);

  localparam int DIV  = seg7_div(CLK_HZ, DIGIT_HZ);
  localparam int PCW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDXW = $clog2(NDIGITS);
  localparam logic [PCW-1:0]     PC_LAST  = PCW'(DIV - 1);
  localparam logic [IDXW-1:0]    IDX_LAST = IDXW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] AN_ONE   = NDIGITS'(1);

  logic [PCW-1:0]       pc_r;
  logic [IDXW-1:0]      idx_r;
  logic [4*NDIGITS-1:0] val_p_r, val_d_r;
  logic                 err_p_r, good_p_r, err_d_r, good_d_r;
  logic                 ready_r;
  logic [6:0]           seg_r;
  logic                 dp_r;
  logic [NDIGITS-1:0]   an_r;

  logic                 tick_s, frame_s, lzb_s, hi_zero_s;
  logic [3:0]           nibble_s;
  logic [6:0]           glyph_s;

  assign tick_s  = (pc_r == PC_LAST);
  assign frame_s = tick_s && (idx_r == IDX_LAST);

  // Current digit's nibble and whether it and every higher nibble are zero.
  always_comb begin
    nibble_s  = 4'h0;
    hi_zero_s = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (IDXW'(i) == idx_r) nibble_s = val_d_r[4*i +: 4];
      else                   nibble_s = nibble_s;
      if (IDXW'(i) >= idx_r && val_d_r[4*i +: 4] != 4'h0) hi_zero_s = 1'b0;
      else                                                hi_zero_s = hi_zero_s;
    end
`ifdef SEG7_LZB_EN
    lzb_s = hi_zero_s && (idx_r != {IDXW{1'b0}});
`else
    lzb_s = 1'b0;
`endif
  end

  seg7_glyph_sel #(.NDIGITS(NDIGITS), .IDXW(IDXW)) u_glyph (
    .nibble (nibble_s),
    .idx    (idx_r),
    .err_d  (err_d_r),
    .good_d (good_d_r),
    .lzb    (lzb_s),
    .glyph  (glyph_s)
  );

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r  <= {PCW{1'b0}};
      idx_r <= {IDXW{1'b0}};
    end else if (tick_s) begin
      pc_r  <= {PCW{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? {IDXW{1'b0}} : idx_r + 1'b1;
    end else begin
      pc_r  <= pc_r + 1'b1;
    end
  end

  // Load handshake; ready gates both paths so capture and commit never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r  <= 1'b1;
      val_p_r  <= {(4*NDIGITS){1'b0}};
      err_p_r  <= 1'b0;
      good_p_r <= 1'b0;
      val_d_r  <= {(4*NDIGITS){1'b0}};
      err_d_r  <= 1'b0;
      good_d_r <= 1'b0;
    end else if (load && ready_r) begin
      val_p_r  <= value;
      err_p_r  <= err;
      good_p_r <= good;
      ready_r  <= 1'b0;
    end else if (frame_s && !ready_r) begin
      val_d_r  <= val_p_r;
      err_d_r  <= err_p_r;
      good_d_r <= good_p_r;
      ready_r  <= 1'b1;
    end else begin
      ready_r  <= ready_r;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= SEG7_BLANK;
      an_r  <= {NDIGITS{1'b1}};
      dp_r  <= 1'b1;
    end else begin
      seg_r <= glyph_s;
      an_r  <= ~(AN_ONE << idx_r);
      dp_r  <= 1'b1;
    end
  end

  assign ready = ready_r;
  assign seg   = seg_r;
  assign dp    = dp_r;
  assign an    = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit and a 6-digit instance checked against
// an edge-count reference model; LZB expectations follow SEG7_LZB_EN.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] G_BL = 7'b1111111;
  localparam logic [6:0] G_E  = 7'b0110000;
  localparam logic [6:0] G_R  = 7'b1111010;
  localparam logic [6:0] G_G  = 7'b0000100;
  localparam logic [6:0] G_O  = 7'b1100010;
  localparam logic [6:0] G_D  = 7'b1000010;

  logic        clk;
  logic        rst4, load4, err4, good4, ready4, dp4;
  logic [15:0] val4;
  logic [6:0]  seg4;
  logic [3:0]  an4;
  logic        rst6, load6, err6, good6, ready6, dp6;
  logic [23:0] val6;
  logic [6:0]  seg6;
  logic [5:0]  an6;

  int total = 0;
  int bad   = 0;

  int          m_n   [2];
  bit          m_rdy [2];
  logic [23:0] m_pv [2], m_dv [2];
  bit          m_pe [2], m_pg [2], m_de [2], m_dg [2];
  logic [6:0]  exp_seg [2];
  logic [5:0]  exp_an  [2];
  bit          exp_rdy [2];
  logic [6:0]  got [6];

  seg7_scan_driver #(.NDIGITS(4), .CLK_HZ(8), .DIGIT_HZ(2)) dut4 (
    .clk(clk), .reset(rst4), .load(load4), .value(val4), .err(err4), .good(good4),
    .ready(ready4), .seg(seg4), .dp(dp4), .an(an4));

  seg7_scan_driver #(.NDIGITS(6), .CLK_HZ(8), .DIGIT_HZ(2)) dut6 (
    .clk(clk), .reset(rst6), .load(load6), .value(val6), .err(err6), .good(good6),
    .ready(ready6), .seg(seg6), .dp(dp6), .an(an6));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] ref_glyph(int pos, int nd, logic [23:0] v, bit e, bit g);
    int off;
    logic [3:0] nib;
    off = nd - 1 - pos;
    nib = 4'((v >> (4 * pos)) & 24'hF);
    if (e) return (off == 0) ? G_E : (off == 1 || off == 2) ? G_R : G_BL;
    if (g) return (off == 0) ? G_G : (off == 1 || off == 2) ? G_O : (off == 3) ? G_D : G_BL;
`ifdef SEG7_LZB_EN
    if (pos != 0 && (v >> (4 * pos)) == 24'h0) return G_BL;
`endif
    return HEX_TAB[nib];
  endfunction

  // Outputs after edge n show digit ((n-1)/DIV)%nd of the pre-edge display;
  // commits happen on edges where n is a multiple of the frame length.
  task automatic model_edge(int d, bit rst, bit ld, logic [23:0] v, bit e, bit g);
    int nd, fr, pos;
    nd = (d == 1) ? 6 : 4;
    fr = nd * DIV;
    if (rst) begin
      m_n[d] = 0; m_rdy[d] = 1'b1;
      m_pv[d] = 24'h0; m_pe[d] = 1'b0; m_pg[d] = 1'b0;
      m_dv[d] = 24'h0; m_de[d] = 1'b0; m_dg[d] = 1'b0;
      exp_seg[d] = G_BL; exp_an[d] = 6'h3F;
    end else begin
      m_n[d] = m_n[d] + 1;
      pos = ((m_n[d] - 1) / DIV) % nd;
      exp_an[d]  = ~(6'd1 << pos);
      exp_seg[d] = ref_glyph(pos, nd, m_dv[d], m_de[d], m_dg[d]);
      if (!m_rdy[d] && (m_n[d] % fr) == 0) begin
        m_dv[d] = m_pv[d]; m_de[d] = m_pe[d]; m_dg[d] = m_pg[d]; m_rdy[d] = 1'b1;
      end else if (ld && m_rdy[d]) begin
        m_pv[d] = v; m_pe[d] = e; m_pg[d] = g; m_rdy[d] = 1'b0;
      end
    end
    exp_rdy[d] = m_rdy[d];
  endtask

  task automatic cyc();
    model_edge(0, rst4, load4, {8'h00, val4}, err4, good4);
    model_edge(1, rst6, load6, val6, err6, good6);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    rst4 = 1'b1; rst6 = 1'b1; load4 = 1'b0; load6 = 1'b0;
    err4 = 1'b0; good4 = 1'b0; err6 = 1'b0; good6 = 1'b0;
    val4 = 16'h0; val6 = 24'h0;
    cyc(); cyc();
    total++;
    if (seg4 !== 7'b1111111 || an4 !== 4'b1111 || dp4 !== 1'b1 || ready4 !== 1'b1) begin
      bad++;
      $display("FAIL reset4 seg=%b an=%b dp=%b ready=%b want 1111111 1111 1 1", seg4, an4, dp4, ready4);
    end
    total++;
    if (seg6 !== 7'b1111111 || an6 !== 6'b111111 || dp6 !== 1'b1 || ready6 !== 1'b1) begin
      bad++;
      $display("FAIL reset6 seg=%b an=%b dp=%b ready=%b want 1111111 111111 1 1", seg6, an6, dp6, ready6);
    end
    rst4 = 1'b0; rst6 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      ea = ~(4'b0001 << (i / 4));
      total++;
      if (an4 !== ea || seg4 !== 7'b0000001 || dp4 !== 1'b1) begin
        bad++;
        $display("FAIL scan4 cyc=%0d an=%b seg=%b dp=%b want an=%b seg=0000001 dp=1", i, an4, seg4, dp4, ea);
      end
      total++;
      if (an6 !== exp_an[1] || seg6 !== exp_seg[1]) begin
        bad++;
        $display("FAIL scan6 cyc=%0d an=%b seg=%b want an=%b seg=%b", i, an6, seg6, exp_an[1], exp_seg[1]);
      end
    end
  endtask

  task automatic test_load_and_ignore();
    logic [6:0] want [4];
    want = '{7'b0111000, 7'b0000110, 7'b0001000, 7'b1001111};
    for (int k = 0; k < 16 && (m_n[0] % 16) != 2; k++) cyc();
    load4 = 1'b1; val4 = 16'h1A3F;
    cyc();
    total++;
    if (ready4 !== 1'b0) begin bad++; $display("FAIL load_ready got=%b want=0", ready4); end
    val4 = 16'hFFFF;
    cyc();
    load4 = 1'b0;
    total++;
    if (ready4 !== 1'b0) begin bad++; $display("FAIL ignored_ready got=%b want=0", ready4); end
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (seg4 !== exp_seg[0] || an4 !== exp_an[0][3:0] || ready4 !== exp_rdy[0]) begin
        bad++;
        $display("FAIL load_seq n=%0d seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 m_n[0], seg4, an4, ready4, exp_seg[0], exp_an[0][3:0], exp_rdy[0]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cyc();
      for (int j = 0; j < 4; j++) if (an4[j] == 1'b0) got[j] = seg4;
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (got[j] !== want[j]) begin
        bad++;
        $display("FAIL load_glyph digit=%0d got=%b want=%b", j, got[j], want[j]);
      end
    end
  endtask

  task automatic test_status();
    logic [6:0] want_e [4];
    logic [6:0] want_g [4];
    want_e = '{G_BL, G_R, G_R, G_E};
    want_g = '{G_D, G_O, G_O, G_G};
    for (int pass = 0; pass < 2; pass++) begin
      total++;
      if (ready4 !== 1'b1) begin bad++; $display("FAIL status_ready pass=%0d got=%b want=1", pass, ready4); end
      load4 = 1'b1; err4 = (pass == 0); good4 = 1'b1; val4 = 16'h1234;
      cyc();
      load4 = 1'b0; err4 = 1'b0; good4 = 1'b0;
      for (int i = 0; i < 32; i++) begin
        cyc();
        total++;
        if (seg4 !== exp_seg[0] || an4 !== exp_an[0][3:0] || ready4 !== exp_rdy[0]) begin
          bad++;
          $display("FAIL status_seq n=%0d seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                   m_n[0], seg4, an4, ready4, exp_seg[0], exp_an[0][3:0], exp_rdy[0]);
        end
      end
      for (int i = 0; i < 16; i++) begin
        cyc();
        for (int j = 0; j < 4; j++) if (an4[j] == 1'b0) got[j] = seg4;
      end
      for (int j = 0; j < 4; j++) begin
        total++;
        if (got[j] !== ((pass == 0) ? want_e[j] : want_g[j])) begin
          bad++;
          $display("FAIL status_glyph pass=%0d digit=%0d got=%b want=%b", pass, j, got[j],
                   (pass == 0) ? want_e[j] : want_g[j]);
        end
      end
    end
  endtask

  task automatic test_ndigits6();
    logic [6:0] want [6];
    want = '{G_BL, G_BL, G_D, G_O, G_O, G_G};
    load6 = 1'b1; good6 = 1'b1; val6 = 24'hABCDEF;
    cyc();
    load6 = 1'b0; good6 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      total++;
      if (seg6 !== exp_seg[1] || an6 !== exp_an[1] || ready6 !== exp_rdy[1]) begin
        bad++;
        $display("FAIL nd6_seq n=%0d seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 m_n[1], seg6, an6, ready6, exp_seg[1], exp_an[1], exp_rdy[1]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      cyc();
      for (int j = 0; j < 6; j++) if (an6[j] == 1'b0) got[j] = seg6;
    end
    for (int j = 0; j < 6; j++) begin
      total++;
      if (got[j] !== want[j]) begin
        bad++;
        $display("FAIL nd6_glyph digit=%0d got=%b want=%b", j, got[j], want[j]);
      end
    end
  endtask

  task automatic test_lzb_and_reset_mid();
    logic [6:0] want [4];
`ifdef SEG7_LZB_EN
    want = '{7'b0000001, 7'b0100100, G_BL, G_BL};
`else
    want = '{7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001};
`endif
    load4 = 1'b1; val4 = 16'h0050;
    cyc();
    load4 = 1'b0;
    for (int i = 0; i < 32; i++) cyc();
    for (int i = 0; i < 16; i++) begin
      cyc();
      for (int j = 0; j < 4; j++) if (an4[j] == 1'b0) got[j] = seg4;
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (got[j] !== want[j]) begin
        bad++;
        $display("FAIL lzb_glyph digit=%0d got=%b want=%b", j, got[j], want[j]);
      end
    end
    for (int k = 0; k < 16 && (m_n[0] % 16) != 3; k++) cyc();
    load4 = 1'b1; val4 = 16'h1234;
    cyc();
    load4 = 1'b0;
    cyc(); cyc();
    rst4 = 1'b1;
    cyc();
    total++;
    if (an4 !== 4'b1111 || ready4 !== 1'b1 || seg4 !== 7'b1111111) begin
      bad++;
      $display("FAIL reset_mid an=%b ready=%b seg=%b want 1111 1 1111111", an4, ready4, seg4);
    end
    rst4 = 1'b0;
    cyc();
    total++;
    if (an4 !== 4'b1110 || seg4 !== 7'b0000001) begin
      bad++;
      $display("FAIL after_reset an=%b seg=%b want 1110 0000001", an4, seg4);
    end
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++;
      if (seg4 !== exp_seg[0] || an4 !== exp_an[0][3:0] || ready4 !== exp_rdy[0]) begin
        bad++;
        $display("FAIL discard_seq n=%0d seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 m_n[0], seg4, an4, ready4, exp_seg[0], exp_an[0][3:0], exp_rdy[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load4 = ($urandom_range(0, 5) == 0);
      val4  = 16'($urandom());
      err4  = ($urandom_range(0, 3) == 0);
      good4 = ($urandom_range(0, 3) == 0);
      load6 = ($urandom_range(0, 5) == 0);
      val6  = 24'($urandom());
      err6  = ($urandom_range(0, 3) == 0);
      good6 = ($urandom_range(0, 3) == 0);
      cyc();
      total++;
      if (seg4 !== exp_seg[0] || an4 !== exp_an[0][3:0] || ready4 !== exp_rdy[0] || dp4 !== 1'b1) begin
        bad++;
        $display("FAIL rand4 n=%0d seg=%b an=%b rdy=%b dp=%b want seg=%b an=%b rdy=%b dp=1",
                 m_n[0], seg4, an4, ready4, dp4, exp_seg[0], exp_an[0][3:0], exp_rdy[0]);
      end
      total++;
      if (seg6 !== exp_seg[1] || an6 !== exp_an[1] || ready6 !== exp_rdy[1]) begin
        bad++;
        $display("FAIL rand6 n=%0d seg=%b an=%b rdy=%b want seg=%b an=%b rdy=%b",
                 m_n[1], seg6, an6, ready6, exp_seg[1], exp_an[1], exp_rdy[1]);
      end
    end
    load4 = 1'b0; load6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_and_ignore();
    test_status();
    test_ndigits6();
    test_lzb_and_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
